// File: rtl/burst_fault_pkg.sv
// Shared constants for the burst fault injector.
//   MODE_*            campaign mode encodings carried on cfg_mode
//   LFSR_TAPS         Galois feedback mask for x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT_SEED default random-campaign seed
//   lfsr_next()       one Galois step (shift right, xor taps when bit0 was set)
package burst_fault_pkg;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_SWEEP  = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/burst_mask_gen.sv
// Combinational burst mask: sets bits start..start+len of a DATA_W word.
// Bits that would land at or above DATA_W are dropped (clipped at the MSB,
// never wrapped); a start at or beyond DATA_W yields an all-zero mask.
//   start  in  ADDR_W  first flipped bit
//   len    in  LEN_W   burst length minus one
//   mask   out DATA_W  resulting flip mask
module burst_mask_gen #(
  parameter  int DATA_W    = 12,
  parameter  int MAX_BURST = 4,
  localparam int ADDR_W    = $clog2(DATA_W),
  localparam int LEN_W     = $clog2(MAX_BURST)
) (
  input  logic [ADDR_W-1:0] start,
  input  logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] mask
);

  // Last covered bit, computed wide so start+len never overflows.
  logic [31:0] last;
  assign last = 32'(start) + 32'(len);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign mask[i] = (32'(i) >= 32'(start)) && (32'(i) <= last);
  end

endmodule

// File: rtl/burst_fault_campaign.sv
// Streaming burst-fault injector. Sits between an encoder and a decoder and
// flips a contiguous bit burst in selected codewords, with fixed, exhaustive
// sweep and pseudo-random campaigns. One registered valid/ready stage.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_code upstream codeword stream
//   out_valid/out_ready       downstream handshake
//   out_error_code            in_code ^ out_err_mask
//   out_err_mask/start/len    burst applied to this word (zeros when clean)
//   cfg_load                  pulse: latch cfg_*, restart campaign
//   cfg_en/mode/start/len     campaign configuration
//   cfg_interval              inject every (cfg_interval+1)-th accepted word
//   inject_count              saturating injected-word count
//   sweep_done                sticky, sweep campaign exhausted
// Build option: define FAULT_RANDOM_EN to build the LFSR and RANDOM mode;
// without it mode 2 is pass-through like the reserved mode.
module burst_fault_campaign
  import burst_fault_pkg::*;
#(
  parameter  int          DATA_W    = 12,
  parameter  int          MAX_BURST = 4,
  parameter  int          CNT_W     = 16,
  parameter  logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
  localparam int          ADDR_W    = $clog2(DATA_W),
  localparam int          LEN_W     = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_error_code,
  output logic [DATA_W-1:0] out_err_mask,
  output logic [ADDR_W-1:0] out_start,
  output logic [LEN_W-1:0]  out_len,
  input  logic              cfg_load,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_interval,
  output logic [CNT_W-1:0]  inject_count,
  output logic              sweep_done
);

  // Working configuration, only changed by cfg_load.
  typedef struct packed {
    logic              en;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  interval;
  } cfg_t;

  cfg_t              w_cfg;
  logic [CNT_W-1:0]  ctr;
  logic [ADDR_W-1:0] sw_start;
  logic [LEN_W-1:0]  sw_len;

  logic              accept, active, hit, inject, mode_ok;
  logic [ADDR_W-1:0] sel_start, rand_start;
  logic [LEN_W-1:0]  sel_len, rand_len;
  logic [DATA_W-1:0] gen_mask, word_mask;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef FAULT_RANDOM_EN
  // A zero seed would lock the LFSR, so random mode stays off in that case.
  localparam bit RAND_AVAIL = (LFSR_SEED != 16'h0);

  logic [15:0]       lfsr;
  logic [ADDR_W-1:0] lfsr_lo;

  assign lfsr_lo    = lfsr[ADDR_W-1:0];
  assign rand_start = (32'(lfsr_lo) >= 32'(DATA_W)) ? lfsr_lo - ADDR_W'(DATA_W) : lfsr_lo;
  assign rand_len   = lfsr[ADDR_W +: LEN_W];

  // Steps after its value was used, only on injected random-mode words.
  always_ff @(posedge clk) begin
    if (rst || cfg_load)                                 lfsr <= LFSR_SEED;
    else if (accept && inject && w_cfg.mode == MODE_RANDOM) lfsr <= lfsr_next(lfsr);
  end
`else
  // No LFSR in this build: mode 2 falls back to pass-through.
  localparam bit RAND_AVAIL = 1'b0 && (LFSR_SEED != 16'h0);

  assign rand_start = '0;
  assign rand_len   = '0;
`endif

  always_comb begin
    mode_ok = 1'b0;
    case (w_cfg.mode)
      MODE_FIXED:  mode_ok = 1'b1;
      MODE_SWEEP:  mode_ok = 1'b1;
      MODE_RANDOM: mode_ok = RAND_AVAIL;
      MODE_RSVD:   mode_ok = 1'b0;
    endcase
  end

  assign active = w_cfg.en && mode_ok;
  assign hit    = (ctr == w_cfg.interval);

  // Burst selection for the word currently on the input.
  always_comb begin
    inject    = 1'b0;
    sel_start = '0;
    sel_len   = '0;
    if (active && hit) begin
      case (w_cfg.mode)
        MODE_FIXED: begin
          inject    = 1'b1;
          sel_start = w_cfg.start;
          sel_len   = w_cfg.len;
        end
        MODE_SWEEP: begin
          // Once exhausted, words pass clean and are not counted.
          inject    = !sweep_done;
          sel_start = sweep_done ? '0 : sw_start;
          sel_len   = sweep_done ? '0 : sw_len;
        end
        default: begin
          inject    = 1'b1;
          sel_start = rand_start;
          sel_len   = rand_len;
        end
      endcase
    end
  end

  burst_mask_gen #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_mask (
    .start (sel_start),
    .len   (sel_len),
    .mask  (gen_mask)
  );

  // The generator sees (0,0) on clean words, which would still set bit 0.
  assign word_mask = inject ? gen_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_error_code <= '0;
      out_err_mask   <= '0;
      out_start      <= '0;
      out_len        <= '0;
      w_cfg          <= '0;
      ctr            <= '0;
      inject_count   <= '0;
      sweep_done     <= 1'b0;
      sw_start       <= '0;
      sw_len         <= '0;
    end else begin
      // Output register: load on accept, otherwise hold until drained.
      if (accept) begin
        out_valid      <= 1'b1;
        out_error_code <= in_code ^ word_mask;
        out_err_mask   <= word_mask;
        out_start      <= sel_start;
        out_len        <= sel_len;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // cfg_load wins over same-cycle bookkeeping; the word itself still
      // went out above with the old configuration.
      if (cfg_load) begin
        w_cfg        <= '{en: cfg_en, mode: cfg_mode, start: cfg_start,
                          len: cfg_len, interval: cfg_interval};
        ctr          <= '0;
        inject_count <= '0;
        sweep_done   <= 1'b0;
        sw_start     <= '0;
        sw_len       <= '0;
      end else if (accept && active) begin
        ctr <= hit ? '0 : ctr + CNT_W'(1);
        if (inject && inject_count != '1)
          inject_count <= inject_count + CNT_W'(1);
        if (inject && w_cfg.mode == MODE_SWEEP) begin
          if (sw_start == ADDR_W'(DATA_W - 1)) begin
            sw_start <= '0;
            if (sw_len == LEN_W'(MAX_BURST - 1)) sweep_done <= 1'b1;
            else                                 sw_len     <= sw_len + LEN_W'(1);
          end else begin
            sw_start <= sw_start + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_fault_campaign.sv
module tb_burst_fault_campaign;

  localparam int DW  = 12;
  localparam int MB  = 4;
  localparam int NSW = DW * MB;
`ifdef FAULT_RANDOM_EN
  localparam bit RAND = 1'b1;
`else
  localparam bit RAND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_error_code, out_err_mask;
  logic [3:0]  out_start;
  logic [1:0]  out_len;
  logic        cfg_load = 1'b0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_start = '0;
  logic [1:0]  cfg_len = '0;
  logic [15:0] cfg_interval = '0;
  logic [15:0] inject_count;
  logic        sweep_done;

  burst_fault_campaign #(
    .DATA_W(DW), .MAX_BURST(MB), .CNT_W(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_error_code(out_error_code), .out_err_mask(out_err_mask),
    .out_start(out_start), .out_len(out_len),
    .cfg_load(cfg_load), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_interval(cfg_interval),
    .inject_count(inject_count), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Campaign state kept as plain integers: sweep progress is a single
  // word index (start = idx % DW, len = idx / DW).
  bit          m_ov;
  logic [11:0] m_code, m_mask;
  int          m_st, m_ln, m_cnt, m_ctr, m_sidx;
  bit          m_en;
  int          m_mode, m_cstart, m_clen, m_int;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    // x^16 + x^14 + x^13 + x^11 + 1 in Galois right-shift form
    if (s[0]) r = r ^ ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10));
    return r;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_code = '0; m_mask = '0; m_st = 0; m_ln = 0;
    m_cnt = 0; m_ctr = 0; m_sidx = 0; m_lfsr = 16'hACE1;
    m_en = 0; m_mode = 0; m_cstart = 0; m_clen = 0; m_int = 0;
  endtask

  task automatic model_step();
    bit acc, act, fire, inj;
    int st, ln;
    logic [31:0] msk;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && (!m_ov || out_ready);
    if (acc) begin
      inj = 0; st = 0; ln = 0; msk = 0;
      act = m_en && (m_mode == 0 || m_mode == 1 || (RAND && m_mode == 2));
      if (act) begin
        fire  = (m_ctr == m_int);
        m_ctr = fire ? 0 : m_ctr + 1;
        if (fire) begin
          if (m_mode == 0) begin
            inj = 1; st = m_cstart; ln = m_clen;
          end else if (m_mode == 1) begin
            if (m_sidx < NSW) begin
              inj = 1; st = m_sidx % DW; ln = m_sidx / DW; m_sidx++;
            end
          end else begin
            inj = 1;
            st = int'(m_lfsr[3:0]);
            if (st >= DW) st -= DW;
            ln = int'(m_lfsr[5:4]);
            m_lfsr = lfsr_adv(m_lfsr);
          end
        end
        if (inj) begin
          msk = (((32'd1 << (ln + 1)) - 32'd1) << st) & 32'hFFF;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      m_ov = 1; m_code = in_code ^ msk[11:0]; m_mask = msk[11:0]; m_st = st; m_ln = ln;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (cfg_load) begin
      m_en = cfg_en; m_mode = int'(cfg_mode); m_cstart = int'(cfg_start);
      m_clen = int'(cfg_len); m_int = int'(cfg_interval);
      m_ctr = 0; m_cnt = 0; m_sidx = 0; m_lfsr = 16'hACE1;
    end
  endtask

  // Compare the outputs produced by the last edge, then advance the model
  // across the next edge using the (stable) inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_error_code", 32'(out_error_code), 32'(m_code));
        chk("out_err_mask", 32'(out_err_mask), 32'(m_mask));
        chk("out_start", 32'(out_start), 32'(m_st));
        chk("out_len", 32'(out_len), 32'(m_ln));
      end
      chk("inject_count", 32'(inject_count), 32'(m_cnt));
      chk("sweep_done", 32'(sweep_done), 32'(m_sidx == NSW));
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Holds in_valid with the code until it is accepted (bounded wait).
  task automatic send(input logic [11:0] c);
    bit got;
    int n;
    n = 0;
    in_valid = 1'b1; in_code = c;
    forever begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
      if (got) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no acceptance, expected one within 50 cycles");
        break;
      end
    end
  endtask

  task automatic cfg(input bit en, input int mode, input int st, input int ln, input int itv);
    idle();
    cfg_en = en; cfg_mode = 2'(mode); cfg_start = 4'(st); cfg_len = 2'(ln);
    cfg_interval = 16'(itv);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected one before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mask", 32'(out_err_mask), 32'd0);
    chk("rst_count", 32'(inject_count), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    rst = 1'b0; chk_en = 1'b1;
    tick();

    // Default working config is disabled: pass-through
    send(12'h5A5); idle();
    chk("passthru_code", 32'(out_error_code), 32'h5A5);

    // FIXED start=3 len=2 every word
    cfg(1, 0, 3, 2, 0);
    send(12'h000);
    chk("fixed_code", 32'(out_error_code), 32'h038);
    chk("fixed_count1", 32'(inject_count), 32'd1);
    send(12'hFFF);
    chk("fixed_code2", 32'(out_error_code), 32'hFC7);
    send(12'h123); send(12'h800); idle();
    chk("fixed_count4", 32'(inject_count), 32'd4);

    // FIXED clipped at MSB, then start beyond the word
    cfg(1, 0, 10, 3, 0);
    send(12'h123); idle();
    chk("clip_mask", 32'(out_err_mask), 32'hC00);
    cfg(1, 0, 12, 1, 0);
    send(12'h777); idle();
    chk("oob_mask", 32'(out_err_mask), 32'h000);
    chk("oob_count", 32'(inject_count), 32'd1);

    // cfg_en=0 leaves words untouched
    cfg(0, 0, 0, 3, 0);
    send(12'h00F); idle();
    chk("disabled_mask", 32'(out_err_mask), 32'h000);

    // SWEEP over all 48 (start,len) pairs, 50 words streamed back to back
    cfg(1, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      send(12'((i * 37) & 12'hFFF));
      if (i == 0)  chk("sweep_first_mask", 32'(out_err_mask), 32'h001);
      if (i == 12) chk("sweep_len1_mask", 32'(out_err_mask), 32'h003);
      if (i == 47) chk("sweep_done_at48", 32'(sweep_done), 32'd1);
    end
    idle();
    chk("sweep_last_clean", 32'(out_err_mask), 32'h000);
    chk("sweep_count", 32'(inject_count), 32'd48);

    // Interval=2 over 9 words with a 3-cycle downstream stall mid-stream
    cfg(1, 0, 0, 0, 2);
    for (int i = 1; i <= 4; i++) begin
      send(12'(i * 16));
      if (i == 2) chk("itv_w2_clean", 32'(out_err_mask), 32'h000);
      if (i == 3) chk("itv_w3_hit", 32'(out_err_mask), 32'h001);
    end
    out_ready = 1'b0;
    fork
      begin repeat (3) tick(); out_ready = 1'b1; end
      send(12'h050);
    join
    for (int i = 6; i <= 9; i++) send(12'(i * 16));
    idle();
    chk("itv_w9_hit", 32'(out_err_mask), 32'h001);
    chk("itv_count", 32'(inject_count), 32'd3);
    tick();

    // cfg_load in the same cycle as a transfer: word uses old config
    cfg(1, 0, 1, 0, 0);
    send(12'h000); // one injection under the new config
    in_valid = 1'b1; in_code = 12'h000;
    cfg_mode = 2'd3; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0; idle();
    chk("load_xfer_old_mask", 32'(out_err_mask), 32'h002);
    chk("load_xfer_count_clr", 32'(inject_count), 32'd0);
    send(12'h000); idle();
    chk("load_new_rsvd_mask", 32'(out_err_mask), 32'h000);
    tick();

    // Reset while a word is held at the output
    out_ready = 1'b0;
    send(12'hABC); idle();
    rst = 1'b1; tick();
    chk("rst_drop_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();

    // RANDOM campaign from the seed, 1000 words
    cfg(1, 2, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      send(12'((i * 53) & 12'hFFF));
      if (RAND) chk("rand_start_lt12", 32'(out_start < 4'd12), 32'd1);
      else if (i % 100 == 0) chk("rand_off_mask", 32'(out_err_mask), 32'h000);
    end
    idle();
    chk("rand_count", 32'(inject_count), RAND ? 32'd1000 : 32'd0);
    tick(); tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
